// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register file of the single-cycle core.
package rv_pkg;
  localparam int unsigned XLEN_C     = 32;
  localparam int unsigned NREG_C     = 32;
  localparam int unsigned REG_AW_C   = 5;
  localparam logic [4:0]  REG_ZERO_C = 5'd0;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_t;
endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks x1..x(NREG-1) one per cycle and flags init_busy
// until the last entry has been zeroed.
module rf_clear_seq
  import rv_pkg::*;
#(
  parameter int unsigned NREG = NREG_C,
  parameter int unsigned AW   = REG_AW_C
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_busy
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_entry;

  assign last_entry = (cnt_q == AW'(NREG - 1));

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = RF_INIT;
      cnt_d   = AW'(1);
    end else begin
      unique case (state_q)
        RF_INIT: begin
          // Hold cnt on the final step so it never wraps to x0.
          if (last_entry) begin
            state_d = RF_RUN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        RF_RUN:  state_d = RF_RUN;
        default: state_d = RF_INIT;
      endcase
    end
  end

  always_comb begin
    init_busy = (state_q == RF_INIT);
    clr_we    = (state_q == RF_INIT) && !rst;
    clr_addr  = cnt_q;
  end

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write integer register file with x0 hardwired to zero.
// Optional write-through forwarding under REGFILE_BYPASS_EN.
module reg_file
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_C,
  parameter int unsigned NREG = NREG_C,
  parameter int unsigned AW   = REG_AW_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            we3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            init_busy
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            core_wr;
  logic            core_we;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  rf_clear_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  // core_wr qualifies forwarding; core_we additionally lets reset win over the write.
  assign core_wr = !init_busy && we3 && (a3 != '0);
  assign core_we = core_wr && !rst;

  always_comb begin
    wr_en   = clr_we || core_we;
    wr_addr = clr_we ? clr_addr : a3;
    wr_data = clr_we ? '0 : wd3;
  end

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREG); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    rd1 = mem_q[a1];
    rd2 = mem_q[a2];
`ifdef REGFILE_BYPASS_EN
    if (core_wr && (a1 == a3)) begin
      rd1 = wd3;
    end
    if (core_wr && (a2 == a3)) begin
      rd2 = wd3;
    end
`endif
    if (init_busy || (a1 == '0)) begin
      rd1 = '0;
    end
    if (init_busy || (a2 == '0)) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: vector table with scoreboard queue plus
// reset / clear-sequence corner cases.
module tb_reg_file;
  import rv_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic        we3;
  logic [31:0] rd1, rd2;
  logic        init_busy;

  int total;
  int bad;

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NVec = 13;
  vec_t        vecs [NVec];
  logic [63:0] sb_q [$];

  reg_file u_dut (
    .clk       (clk),
    .rst       (rst),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .wd3       (wd3),
    .we3       (we3),
    .rd1       (rd1),
    .rd2       (rd2),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts consecutive busy cycles starting with the current one; reads of
  // a1=5/a2=31 must be zero throughout.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (!init_busy) break;
      n++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        check("init_read", {rd1 | rd2}, 32'h0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [63:0] e;
    total = 0;
    bad   = 0;
    rst = 1'b0; we3 = 1'b0; a1 = 5'd5; a2 = 5'd31; a3 = 5'd0; wd3 = 32'h0;

    vecs[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd0,  Byp ? 32'hDEADBEEF : 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd31, 32'h1,        5'd31, 5'd1,  Byp ? 32'h1 : 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 5'd1,  32'hFFFFFFFF, 5'd31, 5'd1,  32'h1, Byp ? 32'hFFFFFFFF : 32'h0};
    vecs[6]  = '{1'b0, 5'd1,  32'h0,        5'd31, 5'd1,  32'h1, 32'hFFFFFFFF};
    vecs[7]  = '{1'b1, 5'd4,  32'hA5A5A5A5, 5'd2,  5'd7,  32'h0, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 5'd3,  32'h00000033, 5'd4,  5'd31, 32'hA5A5A5A5, 32'h1};
    vecs[9]  = '{1'b1, 5'd7,  32'h00001111, 5'd3,  5'd7,  32'h33, Byp ? 32'h1111 : 32'hDEADBEEF};
    vecs[10] = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd4,  32'h1111, 32'hA5A5A5A5};
    vecs[11] = '{1'b1, 5'd0,  32'hCAFEF00D, 5'd3,  5'd0,  32'h33, 32'h0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'hFFFFFFFF, 32'h1};

    // Reset, then clear sequence must last exactly 31 cycles.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check("busy_after_rst", {31'd0, init_busy}, 32'h1);
    count_busy(n);
    check("init_len", n, 32'd31);
    check("busy_run", {31'd0, init_busy}, 32'h0);

    // Vector table through a scoreboard.
    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      we3 = vecs[i].we3; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
      a1 = vecs[i].a1; a2 = vecs[i].a2;
      sb_q.push_back({vecs[i].e1, vecs[i].e2});
      #2;
      e = sb_q.pop_front();
      check($sformatf("v%0d_rd1", i), rd1, e[63:32]);
      check($sformatf("v%0d_rd2", i), rd2, e[31:0]);
    end

    // Reset in RUN with a colliding write: reset wins.
    @(negedge clk);
    rst = 1'b1; we3 = 1'b1; a3 = 5'd4; wd3 = 32'h9; a1 = 5'd5; a2 = 5'd31;
    @(negedge clk);
    rst = 1'b0; a3 = 5'd3; wd3 = 32'h5;
    #1 check("busy_after_run_rst", {31'd0, init_busy}, 32'h1);
    // Ten INIT cycles with a core write attempt that must be dropped.
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; we3 = 1'b0;
    count_busy(n);
    check("restart_len", n, 32'd31);

    a1 = 5'd4; a2 = 5'd3;
    #1;
    check("x4_cleared", rd1, 32'h0);
    check("x3_cleared", rd2, 32'h0);
    a1 = 5'd7; a2 = 5'd1;
    #1;
    check("x7_cleared", rd1, 32'h0);
    check("x1_cleared", rd2, 32'h0);

    // Normal writes resume after the clear.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h5;
    @(negedge clk);
    we3 = 1'b0; a1 = 5'd3; a2 = 5'd0;
    #2;
    check("x3_post", rd1, 32'h5);
    check("x0_post", rd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file for the single-cycle RISC-V core.
- Sits directly upstream of the ALU-source 2:1 select: rd2 feeds the select's register-operand input; rd1 feeds the ALU A operand.
- Two combinational read ports and one synchronous write port; x0 is hardwired to zero.
- A post-reset clear sequencer zeroes x1..x(NREG-1) one entry per cycle and flags busy, so the array needs no wide parallel reset.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; must be a power of two and at least 2.
- AW, 5, address width; must equal log2(NREG).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a1  input  AW  read address, port 1 (instr[19:15]).
- a2  input  AW  read address, port 2 (instr[24:20]).
- a3  input  AW  write address (instr[11:7]).
- wd3  input  XLEN  write data.
- we3  input  1  write enable.
- rd1  output  XLEN  read data, port 1.
- rd2  output  XLEN  read data, port 2.
- init_busy  output  1  high while the clear sequence runs; the core must hold the PC while it is high.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled only at the rising edge of clk.
- FSM has two states, INIT and RUN.
  - rst=1 at an edge: next state INIT, clear counter cnt <= 1. Array contents are not touched by that edge.
  - INIT, each edge: mem[cnt] <= 0, then cnt <= cnt+1. At the edge where cnt == NREG-1, the last entry is written and the state moves to RUN.
  - RUN: stays in RUN until rst.
- INIT length is exactly NREG-1 cycles after the reset edge (31 cycles at the defaults).
- init_busy:
  - equals 1 in INIT and 0 in RUN;
  - is 1 in the cycle after any rst edge (it is registered state).
  - Power-up value before the first rst is undefined; the bench always applies rst first.
- Reads:
  - Combinational, zero latency: rd1 = mem[a1], rd2 = mem[a2].
  - A read address of 0 returns 0 in every state.
  - Any read during INIT returns 0, regardless of clear progress.
- Writes:
  - In RUN, if we3=1 and a3 != 0, then mem[a3] <= wd3 at the edge.
  - A write with a3=0 is silently dropped.
  - Writes during INIT are dropped; the clear sequencer owns the write port.
  - A write is visible on the read ports from the cycle after the edge.
- Same-cycle read of the address being written (a1==a3 or a2==a3, we3=1, RUN):
  - without the optional feature, the read returns the old value;
  - with it, see Optional Feature.
- rst mid-INIT restarts the sequence at cnt=1. Entries already cleared stay 0; the sequence clears them again harmlessly.
- rst while in RUN with we3=1 at the same edge: rst wins and the write is dropped.
- Width rules:
  - cnt is AW bits wide; it never wraps, because the state leaves INIT at NREG-1.
  - No sign or width conversion is performed on data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if we3=1, a3 != 0 and a1==a3, then rd1 = wd3 combinationally (write-through). The same rule applies independently to rd2 with a2.
- Not defined: no forwarding; the read returns the stored value.
- x0 and INIT read rules take priority in both builds.

Decomposition:
- Shared package rv_pkg holds:
  - constants XLEN_C=32, NREG_C=32, REG_AW_C=5, REG_ZERO_C=5'd0;
  - enum rf_state_t {RF_INIT, RF_RUN}.
- One natural sub-module, rf_clear_seq: owns the FSM and cnt, and outputs clr_we, clr_addr and init_busy. reg_file muxes the write port between the sequencer and the core.

Test Plan:
- rst high 1 cycle, then low -> init_busy=1 for exactly 31 cycles then 0; during INIT, rd1 and rd2 read 0 for a1=5, a2=31.
- After INIT: we3=1, a3=7, wd3=32'hDEADBEEF; next cycle a1=7 -> rd1=32'hDEADBEEF. In the write cycle itself, rd1=old value (0) without REGFILE_BYPASS_EN and 32'hDEADBEEF with it.
- we3=1, a3=0, wd3=32'h12345678 -> a1=0 and a2=0 read 0 on the following cycle, in both builds.
- Write x31=32'h1, x1=32'hFFFFFFFF; read a1=31, a2=1 in the same cycle -> rd1=32'h1, rd2=32'hFFFFFFFF.
- rst asserted at INIT cycle 10, plus we3=1 a3=3 wd3=5 during INIT -> init_busy stays high for 31 cycles after the new rst edge; after completion, x3 reads 0.
- In RUN, x4 = 32'hA5A5A5A5; assert rst with we3=1 a3=4 wd3=9 -> write dropped, INIT runs, x4 reads 0 afterwards.
